// File: rtl/aes256_byte_ctrl_if.sv
// Byte-serial memory, core and control signals for the AES-256 sequencer.
// master = sequencer side, slave = memories / core / host side.
interface aes256_byte_ctrl_if;
   logic         start;
   logic         key_reuse;
   logic         busy;
   logic         done;
   logic         key_valid;
   logic [4:0]   key_addr;
   logic [7:0]   key_dat;
   logic [3:0]   inp_addr;
   logic [7:0]   inp_dat;
   logic [255:0] core_key;
   logic [127:0] core_inp;
   logic [127:0] core_out;
   logic [3:0]   outp_addr;
   logic [7:0]   outp_dat;
   logic         outp_we;

   modport master (
      input  start, key_reuse, key_dat, inp_dat, core_out,
      output busy, done, key_valid, key_addr, inp_addr,
             core_key, core_inp, outp_addr, outp_dat, outp_we
   );

   modport slave (
      output start, key_reuse, key_dat, inp_dat, core_out,
      input  busy, done, key_valid, key_addr, inp_addr,
             core_key, core_inp, outp_addr, outp_dat, outp_we
   );
endinterface

// File: rtl/aes256_byte_ctrl.sv
// Sequencer for a combinational AES-256 core: byte-serial key/plaintext fetch,
// fixed settle wait, then byte-serial ciphertext write-out.
module aes256_byte_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input logic                clk,
   input logic                rst,
   aes256_byte_ctrl_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_KEY, S_INP, S_WAIT, S_OUT, S_DONE} state_t;

   state_t           state, state_d;
   logic [5:0]       step;
   logic [CNT_W-1:0] settle;
   logic [127:0]     result;
   logic             fetch_key;

   assign fetch_key = !(bus.key_reuse && bus.key_valid);

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (bus.start) state_d = fetch_key ? S_KEY : S_INP;
         S_KEY:   if (step == 6'd32) state_d = S_INP;
         S_INP:   if (step == 6'd16) state_d = S_WAIT;
         S_WAIT:  if (settle == CNT_W'(1)) state_d = S_OUT;
         S_OUT:   if (step == 6'd15) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         step          <= '0;
         settle        <= '0;
         result        <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.key_valid <= 1'b0;
         bus.outp_we   <= 1'b0;
         bus.key_addr  <= '0;
         bus.inp_addr  <= '0;
         bus.outp_addr <= '0;
         bus.outp_dat  <= '0;
         bus.core_key  <= '0;
         bus.core_inp  <= '0;
      end else begin
         state       <= state_d;
         bus.busy    <= (state_d != S_IDLE);
         bus.done    <= (state_d == S_DONE);
         bus.outp_we <= (state_d == S_OUT);
         step        <= (state_d != state || state == S_IDLE) ? '0 : step + 6'd1;

         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (fetch_key) begin
                     bus.key_valid <= 1'b0;
                     bus.key_addr  <= '0;
                  end else begin
                     bus.inp_addr  <= '0;
                  end
               end
            end
            // Read data lags the address by one cycle; shifting in from the
            // bottom leaves byte 0 in the top lane after the last capture.
            S_KEY: begin
               if (step != 6'd0) bus.core_key <= {bus.core_key[247:0], bus.key_dat};
               if (step < 6'd31) bus.key_addr <= 5'(step + 6'd1);
               if (step == 6'd32) begin
                  bus.key_valid <= 1'b1;
                  bus.inp_addr  <= '0;
               end
            end
            S_INP: begin
               if (step != 6'd0) bus.core_inp <= {bus.core_inp[119:0], bus.inp_dat};
               if (step < 6'd15) bus.inp_addr <= 4'(step + 6'd1);
               if (step == 6'd16) settle <= CNT_W'(SETTLE_CYCLES);
            end
            S_WAIT: begin
               settle <= settle - CNT_W'(1);
               if (settle == CNT_W'(1)) begin
                  result        <= bus.core_out;
                  bus.outp_addr <= '0;
                  bus.outp_dat  <= bus.core_out[127:120];
               end
            end
            // result shifts up so the next byte is always in lane [119:112].
            S_OUT: begin
               if (step != 6'd15) begin
                  result        <= {result[119:0], 8'h00};
                  bus.outp_addr <= 4'(step + 6'd1);
                  bus.outp_dat  <= result[119:112];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes256_byte_ctrl.sv
// Scoreboard bench for aes256_byte_ctrl: directed runs push expected writes and
// done times; a negedge monitor pops and compares whatever the DUTs present.
module tb_aes256_byte_ctrl;
   localparam logic [255:0] FIPS_K = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_C = 128'h8ea2b7ca516745bfeafc49904b496089;
   // Stand-in core result for key 00..1f on zero plaintext (p ^ khi ^ rotl8(klo)).
   localparam logic [127:0] ZERO_C = 128'h111311171113111f111311171113111f;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic       watch_key = 1'b0;
   logic [4:0] prev_ka = '0;
   int         ka_changes = 0;

   logic [7:0]  key_mem [32];
   logic [7:0]  inp_mem [16];
   logic [11:0] q_out0 [$];
   logic [11:0] q_out1 [$];
   int          q_done0 [$];
   int          q_done1 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes256_byte_ctrl_if b0 ();
   aes256_byte_ctrl_if b1 ();

   aes256_byte_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(b0.master));
   aes256_byte_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

   // Combinational stand-in for the AES core: the real FIPS answer for the FIPS
   // inputs, otherwise a cheap keyed mix so misplaced bytes still show up.
   function automatic logic [127:0] mock_core(input logic [255:0] k, input logic [127:0] p);
      if (k == FIPS_K && p == FIPS_P) return FIPS_C;
      return p ^ k[255:128] ^ {k[119:0], k[127:120]};
   endfunction

   assign b0.core_out = mock_core(b0.core_key, b0.core_inp);
   assign b1.core_out = mock_core(b1.core_key, b1.core_inp);

   always @(posedge clk) begin
      b0.key_dat <= key_mem[b0.key_addr];
      b0.inp_dat <= inp_mem[b0.inp_addr];
      b1.key_dat <= key_mem[b1.key_addr];
      b1.inp_dat <= inp_mem[b1.inp_addr];
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic load_fips();
      logic [255:0] k;
      logic [127:0] p;
      k = FIPS_K;
      p = FIPS_P;
      for (int i = 0; i < 32; i++) key_mem[i] = k[255-8*i -: 8];
      for (int i = 0; i < 16; i++) inp_mem[i] = p[127-8*i -: 8];
   endtask

   task automatic push_run(input int which, input int done_at, input logic [127:0] ct);
      for (int i = 0; i < 16; i++) begin
         if (which == 0) q_out0.push_back({4'(i), ct[127-8*i -: 8]});
         else            q_out1.push_back({4'(i), ct[127-8*i -: 8]});
      end
      if (which == 0) q_done0.push_back(done_at);
      else            q_done1.push_back(done_at);
   endtask

   task automatic go(input logic reuse, output int e0);
      @(negedge clk);
      b0.start     = 1'b1;
      b0.key_reuse = reuse;
      @(posedge clk);
      #1;
      e0           = cyc;
      b0.start     = 1'b0;
      b0.key_reuse = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_idle(input string nm, input int fall_at);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (b0.busy && n < 300);
      if (n >= 300) chk({nm, " timeout"}, 1, 0);
      else          chk({nm, " busy fall cycle"}, cyc, fall_at);
   endtask

   task automatic pulse_start(input int at);
      wait_cyc(at);
      b0.start = 1'b1;
      @(negedge clk);
      b0.start = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [11:0] e;
      if (b0.outp_we) begin
         if (q_out0.size() == 0) chk("dut0 unexpected write", {b0.outp_addr, b0.outp_dat}, 0);
         else begin
            e = q_out0.pop_front();
            chk("dut0 write addr/data", {b0.outp_addr, b0.outp_dat}, e);
         end
      end
      if (b0.done) begin
         if (q_done0.size() == 0) chk("dut0 unexpected done", cyc, 0);
         else chk("dut0 done cycle", cyc, q_done0.pop_front());
      end
      if (b1.outp_we) begin
         if (q_out1.size() == 0) chk("dut1 unexpected write", {b1.outp_addr, b1.outp_dat}, 0);
         else begin
            e = q_out1.pop_front();
            chk("dut1 write addr/data", {b1.outp_addr, b1.outp_dat}, e);
         end
      end
      if (b1.done) begin
         if (q_done1.size() == 0) chk("dut1 unexpected done", cyc, 0);
         else chk("dut1 done cycle", cyc, q_done1.pop_front());
      end
      if (watch_key && b0.key_addr != prev_ka) ka_changes++;
      prev_ka = b0.key_addr;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      b0.start = 1'b0; b0.key_reuse = 1'b0;
      b1.start = 1'b0; b1.key_reuse = 1'b0;
      load_fips();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", b0.busy, 0);
      chk("reset done", b0.done, 0);
      chk("reset key_valid", b0.key_valid, 0);
      chk("reset outp_we", b0.outp_we, 0);
      chk("reset key_addr", b0.key_addr, 0);
      chk("reset inp_addr", b0.inp_addr, 0);
      chk("reset outp_addr/dat", {b0.outp_addr, b0.outp_dat}, 0);
      chk("reset core_key", b0.core_key, 0);
      chk("reset core_inp", b0.core_inp, 0);
      chk("reset dut1 busy", b1.busy, 0);
      rst = 1'b0;

      // key_reuse right after reset still fetches the key
      go(1'b1, e0);
      push_run(0, e0 + 70, FIPS_C);
      wait_idle("reuse-without-key", e0 + 71);

      // plain FIPS run; memories scrambled during WAIT must not matter
      go(1'b0, e0);
      push_run(0, e0 + 70, FIPS_C);
      wait_cyc(e0 + 52);
      for (int i = 0; i < 32; i++) key_mem[i] = 8'hA5;
      for (int i = 0; i < 16; i++) inp_mem[i] = 8'h5A;
      wait_idle("fips", e0 + 71);
      chk("key_valid after fetch", b0.key_valid, 1);
      chk("core_key held", b0.core_key, FIPS_K);

      // key reuse on zero plaintext
      load_fips();
      for (int i = 0; i < 16; i++) inp_mem[i] = 8'h00;
      watch_key = 1'b1;
      go(1'b1, e0);
      push_run(0, e0 + 37, ZERO_C);
      wait_idle("reuse", e0 + 38);
      watch_key = 1'b0;
      chk("reuse key_addr changes", ka_changes, 0);
      load_fips();

      // reset during WAIT aborts the run
      go(1'b0, e0);
      wait_cyc(e0 + 51);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort busy", b0.busy, 0);
      chk("abort key_valid", b0.key_valid, 0);
      chk("abort outp_we", b0.outp_we, 0);
      chk("abort done", b0.done, 0);
      rst = 1'b0;
      go(1'b0, e0);
      push_run(0, e0 + 70, FIPS_C);
      wait_idle("after abort", e0 + 71);

      // start pulses during INP and OUT are ignored
      go(1'b0, e0);
      push_run(0, e0 + 70, FIPS_C);
      pulse_start(e0 + 40);
      pulse_start(e0 + 60);
      wait_idle("ignored start", e0 + 71);
      repeat (20) @(negedge clk);
      chk("ignored start stays idle", b0.busy, 0);

      // SETTLE_CYCLES=1 build, start held: run = 67 cycles, plus DONE and one IDLE
      @(negedge clk);
      b1.start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      for (int k = 0; k < 3; k++) push_run(1, e0 + 67 + 69 * k, FIPS_C);
      repeat (199) @(posedge clk);
      #1;
      b1.start = 1'b0;
      wait_cyc(e0 + 230);
      chk("dut1 idle after held start", b1.busy, 0);

      chk("dut0 writes outstanding", q_out0.size(), 0);
      chk("dut0 dones outstanding", q_done0.size(), 0);
      chk("dut1 writes outstanding", q_out1.size(), 0);
      chk("dut1 dones outstanding", q_done1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
